// File: rtl/morra_cinese.sv
// Rock-paper-scissors referee: per-round verdict and match verdict,
// both combinational from the current state and the current moves.
module morra_cinese (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INIZIA,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        ENDED   = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_P1   = 2'd1,
        W_P2   = 2'd2
    } winner_t;

    localparam logic [1:0] NONE_MV  = 2'b00;
    localparam logic [1:0] ROCK     = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] SCISSORS = 2'b11;

    phase_t             phase, phase_nx;
    winner_t            last_winner, last_winner_nx;
    logic [1:0]         last_move, last_move_nx;
    logic [4:0]         max_rounds, max_rounds_nx;
    logic [4:0]         played, played_nx;
    logic signed [5:0]  diff, diff_nx;

    logic               blocked;
    logic               valid;
    logic               p1_beats;
    logic               draw;
    logic [1:0]         round_res;
    logic [4:0]         played_inc;
    logic signed [5:0]  diff_new;
    logic               lead_end;
    logic [1:0]         match_res;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= IDLE;
            last_winner <= W_NONE;
            last_move   <= NONE_MV;
            max_rounds  <= '0;
            played      <= '0;
            diff        <= '0;
        end else begin
            phase       <= phase_nx;
            last_winner <= last_winner_nx;
            last_move   <= last_move_nx;
            max_rounds  <= max_rounds_nx;
            played      <= played_nx;
            diff        <= diff_nx;
        end
    end

    // The previous winner may not repeat the move that won last time
    always_comb begin
        blocked = 1'b0;
        unique case (1'b1)
            last_winner == W_P1: blocked = (PRIMO == last_move);
            last_winner == W_P2: blocked = (SECONDO == last_move);
            default:             blocked = 1'b0;
        endcase
    end

    assign valid = (phase == PLAYING) && !INIZIA &&
                   (PRIMO != NONE_MV) && (SECONDO != NONE_MV) &&
                   !blocked;

    assign draw     = (PRIMO == SECONDO);
    assign p1_beats = ((PRIMO == ROCK)     && (SECONDO == SCISSORS)) ||
                      ((PRIMO == PAPER)    && (SECONDO == ROCK))     ||
                      ((PRIMO == SCISSORS) && (SECONDO == PAPER));

    always_comb begin
        round_res = 2'b00;
        diff_new  = diff;
        unique case (1'b1)
            draw: begin
                round_res = 2'b11;
                diff_new  = diff;
            end
            p1_beats: begin
                round_res = 2'b01;
                diff_new  = diff + 6'sd1;
            end
            default: begin
                round_res = 2'b10;
                diff_new  = diff - 6'sd1;
            end
        endcase
    end

    assign played_inc = played + 5'd1;
    assign lead_end   = (played_inc >= 5'd4) &&
                        ((diff_new >= 6'sd2) || (diff_new <= -6'sd2));

    always_comb begin
        match_res = 2'b00;
        if (lead_end) begin
            match_res = (diff_new > 6'sd0) ? 2'b01 : 2'b10;
        end else if (played_inc == max_rounds) begin
            if (diff_new > 6'sd0)
                match_res = 2'b01;
            else if (diff_new < 6'sd0)
                match_res = 2'b10;
            else
                match_res = 2'b11;
        end
    end

    // Next-state logic
    always_comb begin
        phase_nx       = phase;
        last_winner_nx = last_winner;
        last_move_nx   = last_move;
        max_rounds_nx  = max_rounds;
        played_nx      = played;
        diff_nx        = diff;
        if (INIZIA) begin
            max_rounds_nx  = {1'b0, PRIMO, SECONDO} + 5'd4;
            played_nx      = '0;
            diff_nx        = '0;
            last_winner_nx = W_NONE;
            phase_nx       = PLAYING;
        end else if (valid) begin
            played_nx = played_inc;
            diff_nx   = diff_new;
            unique case (1'b1)
                draw: begin
                    last_winner_nx = W_NONE;
                end
                p1_beats: begin
                    last_winner_nx = W_P1;
                    last_move_nx   = PRIMO;
                end
                default: begin
                    last_winner_nx = W_P2;
                    last_move_nx   = SECONDO;
                end
            endcase
            if (match_res != 2'b00)
                phase_nx = ENDED;
        end
    end

    // Mealy outputs
    always_comb begin
        MANCHE  = 2'b00;
        PARTITA = 2'b00;
        if (valid) begin
            MANCHE  = round_res;
            PARTITA = match_res;
        end
    end

endmodule

// File: tb/tb_morra_cinese.sv
// Directed bench for morra_cinese: expected verdicts are queued when
// a step is driven and checked in the same cycle, before the edge.
module tb_morra_cinese;

    logic       clk;
    logic       rst_n;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    logic [3:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] S = 2'b11;

    morra_cinese dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INIZIA  (INIZIA),
        .PRIMO   (PRIMO),
        .SECONDO (SECONDO),
        .MANCHE  (MANCHE),
        .PARTITA (PARTITA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string tag);
        logic [3:0] got;
        logic [3:0] want;
        got  = {MANCHE, PARTITA};
        want = exp_q.pop_front();
        n_cmp++;
        assert (got === want)
        else begin
            n_bad++;
            $error("FAIL %s: observed M/P=%b/%b expected %b/%b",
                   tag, got[3:2], got[1:0], want[3:2], want[1:0]);
        end
    endtask

    // Drive one cycle just after the edge and check before the next one
    task automatic step(input string tag, input logic ini,
                        input logic [1:0] p1, input logic [1:0] p2,
                        input logic [1:0] m, input logic [1:0] pt);
        @(posedge clk);
        #1;
        INIZIA  = ini;
        PRIMO   = p1;
        SECONDO = p2;
        exp_q.push_back({m, pt});
        #3;
        check_now(tag);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        INIZIA  = 1'b0;
        PRIMO   = P;
        SECONDO = R;
        #2;
        exp_q.push_back(4'b0000);
        check_now("reset_out");
        #10;
        rst_n = 1'b1;

        step("idle_ignore", 0, P, R, 2'b00, 2'b00);

        // Match 1: max 13, repeat restriction
        step("m1_cfg",     1, P, R, 2'b00, 2'b00);
        step("m1_none",    0, N, N, 2'b00, 2'b00);
        step("m1_p1win",   0, P, R, 2'b01, 2'b00);
        step("m1_p2win",   0, S, R, 2'b10, 2'b00);
        step("m1_nomove",  0, N, P, 2'b00, 2'b00);
        step("m1_rep1",    0, R, R, 2'b00, 2'b00);
        step("m1_rep2",    0, R, R, 2'b00, 2'b00);
        step("m1_rep3",    0, P, R, 2'b00, 2'b00);

        // Match 2: max 5, early lead does not end before 4 rounds
        step("m2_cfg",     1, N, R, 2'b00, 2'b00);
        step("m2_r1",      0, R, P, 2'b10, 2'b00);
        step("m2_r2",      0, S, R, 2'b10, 2'b00);
        step("m2_r3_lead", 0, P, S, 2'b10, 2'b00);
        step("m2_r4_end",  0, S, P, 2'b01, 2'b10);
        step("m2_after",   0, P, R, 2'b00, 2'b00);

        // Match 3: draws count, lead of 2 at round 4
        step("m3_cfg",     1, N, R, 2'b00, 2'b00);
        step("m3_d1",      0, S, S, 2'b11, 2'b00);
        step("m3_d2",      0, S, S, 2'b11, 2'b00);
        step("m3_r3",      0, S, R, 2'b10, 2'b00);
        step("m3_r4_end",  0, P, S, 2'b10, 2'b10);

        // Match 4: reaches max rounds tied
        step("m4_cfg",     1, N, R, 2'b00, 2'b00);
        step("m4_d1",      0, S, S, 2'b11, 2'b00);
        step("m4_d2",      0, S, S, 2'b11, 2'b00);
        step("m4_d3",      0, S, S, 2'b11, 2'b00);
        step("m4_r4",      0, S, R, 2'b10, 2'b00);
        step("m4_r5_tie",  0, R, S, 2'b01, 2'b11);
        step("m4_after1",  0, P, R, 2'b00, 2'b00);
        step("m4_after2",  0, R, S, 2'b00, 2'b00);

        // Match 5: max 19, then async reset mid-match
        step("m5_cfg",     1, S, S, 2'b00, 2'b00);
        step("m5_r1",      0, P, R, 2'b01, 2'b00);
        @(negedge clk);
        rst_n   = 1'b0;
        INIZIA  = 1'b0;
        PRIMO   = R;
        SECONDO = S;
        #1;
        exp_q.push_back(4'b0000);
        check_now("rst_mid");
        #10;
        rst_n = 1'b1;
        step("post_rst",   0, P, R, 2'b00, 2'b00);
        step("post_rst2",  0, R, S, 2'b00, 2'b00);
        step("m6_cfg",     1, N, N, 2'b00, 2'b00);
        step("m6_r1",      0, P, R, 2'b01, 2'b00);
        step("m6_rep",     0, P, S, 2'b00, 2'b00);
        step("m6_r2",      0, R, P, 2'b10, 2'b00);
        step("m6_r3",      0, S, S, 2'b11, 2'b00);
        step("m6_r4_max",  0, S, P, 2'b01, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
